// File: rtl/load_store_sched_if.sv
// Requester <-> scheduler bundle: per-requester req/dir/len in, grant/done/status out.
// Requesters hold req (with stable dir/len) until their done pulse; the scheduler drives everything else.
interface load_store_sched_if #(
    parameter int NREQ  = 2,
    parameter int LBITS = 8,
    parameter int CBITS = 17
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [NREQ*LBITS-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  trunc;
    logic [CBITS-1:0]      vol;
    logic                  full;
    logic                  empty;
    logic                  busy;

    modport master (
        output req, dir, len,
        input  gnt, done, trunc, vol, full, empty, busy
    );

    modport slave (
        input  req, dir, len,
        output gnt, done, trunc, vol, full, empty, busy
    );
endinterface

// File: rtl/load_store_sched.sv
// Round-robin fill/drain scheduler owning a 0..N volume counter, one unit per cycle, bursts clipped at full/empty.
// Grant one cycle after req; done pulses L+1 cycles after grant; requesters wait (req held) while another is served.
module load_store_sched #(
    parameter int N     = 100000,
    parameter int CBITS = 17,
    parameter int NREQ  = 2,
    parameter int LBITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_sched_if.slave bus
);
    localparam int IBITS = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CBITS-1:0] VMAX = CBITS'(N);

    logic [1:0]       state;
    logic [IBITS-1:0] last;
    logic [IBITS-1:0] idx;
    logic [IBITS-1:0] pick;
    logic             pick_vld;
    logic [LBITS-1:0] pick_len;
    logic             fill;
    logic [LBITS-1:0] cnt;
    logic [CBITS-1:0] vol;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             trunc;
    logic             at_limit;

    // Scan from farthest to nearest so the nearest requester after `last` wins.
    always_comb begin
        int c;
        c        = 0;
        pick     = last;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(last) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (bus.req[c]) begin
                pick     = IBITS'(c);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_len = bus.len[int'(pick)*LBITS +: LBITS];
    assign at_limit = fill ? (vol == VMAX) : (vol == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            vol   <= '0;
            gnt   <= '0;
            done  <= '0;
            trunc <= 1'b0;
            last  <= IBITS'(NREQ - 1);
            idx   <= '0;
            fill  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= '0;
                    trunc <= 1'b0;
                    if (pick_vld) begin
                        idx   <= pick;
                        fill  <= bus.dir[pick];
                        cnt   <= pick_len;
                        gnt   <= NREQ'(1) << pick;
                        state <= (pick_len != '0) ? XFER : DONE;
                    end
                end
                XFER: begin
                    if (at_limit) begin
                        state <= DONE;
                        trunc <= 1'b1;
                    end else begin
                        vol <= fill ? vol + CBITS'(1) : vol - CBITS'(1);
                        cnt <= cnt - LBITS'(1);
                        // Landing exactly on a boundary with the last unit is a complete burst.
                        if (cnt == LBITS'(1)) begin
                            state <= DONE;
                            trunc <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    done  <= NREQ'(1) << idx;
                    last  <= idx;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.done  = done;
    assign bus.trunc = trunc;
    assign bus.vol   = vol;
    assign bus.full  = (vol == VMAX);
    assign bus.empty = (vol == '0);
    assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_load_store_sched.sv
// Directed + randomized bench for load_store_sched; expectations come from a per-burst model
// (steps = min(len, headroom), truncated when len exceeds headroom) and a round-robin pick over the req mask.
module tb_load_store_sched;
    localparam int N     = 10;
    localparam int CBITS = 4;
    localparam int NREQ  = 2;
    localparam int LBITS = 8;
    localparam int LW    = NREQ * LBITS;

    logic clk;
    logic rst_n;
    int   comps;
    int   fails;
    int   mvol;
    int   mlast;

    load_store_sched_if #(.NREQ(NREQ), .LBITS(LBITS), .CBITS(CBITS)) bus ();

    load_store_sched #(.N(N), .CBITS(CBITS), .NREQ(NREQ), .LBITS(LBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comps++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit d, input int l);
        bus.req[i] = 1'b1;
        bus.dir[i] = d;
        bus.len[i*LBITS +: LBITS] = LBITS'(l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_vol",   bus.vol, 0);
        check("rst_gnt",   bus.gnt, 0);
        check("rst_done",  bus.done, 0);
        check("rst_trunc", bus.trunc, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full",  bus.full, 0);
        rst_n = 1'b1;
        mvol  = 0;
        mlast = NREQ - 1;
    endtask

    // Serve the next burst; the caller has already set the req mask at a negedge.
    task automatic serve_one(input bit perturb);
        int w, room, steps, g, l, vexp, s;
        bit f, tr;
        w = -1;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(mlast + k) % NREQ]) w = (mlast + k) % NREQ;
        end
        if (w < 0) begin
            comps++;
            fails++;
            $error("FAIL serve_no_req: observed %0d expected %0d", 0, 1);
            return;
        end
        f     = bus.dir[w];
        l     = int'(bus.len[w*LBITS +: LBITS]);
        room  = f ? (N - mvol) : mvol;
        steps = (l < room) ? l : room;
        tr    = (l > room);
        g     = (tr ? steps + 1 : steps) + 1;

        @(posedge clk);
        @(negedge clk);
        check("grant",      bus.gnt, 32'(1) << w);
        check("done_pre",   bus.done, 0);
        check("trunc_pre",  bus.trunc, 0);
        check("busy_grant", bus.busy, 1);
        for (int j = 1; j < g; j++) begin
            if (perturb) begin
                bus.dir = NREQ'($urandom);
                bus.len = LW'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            s    = (j < steps) ? j : steps;
            vexp = f ? mvol + s : mvol - s;
            check("gnt_hold",  bus.gnt, 32'(1) << w);
            check("vol_step",  bus.vol, vexp);
            check("done_hold", bus.done, 0);
        end
        @(posedge clk);
        @(negedge clk);
        mvol = f ? mvol + steps : mvol - steps;
        check("done_pulse", bus.done, 32'(1) << w);
        check("gnt_off",    bus.gnt, 0);
        check("trunc",      bus.trunc, tr);
        check("vol_final",  bus.vol, mvol);
        check("full",       bus.full, (mvol == N));
        check("empty",      bus.empty, (mvol == 0));
        check("busy_done",  bus.busy, 0);
        mlast      = w;
        bus.req[w] = 1'b0;
    endtask

    task automatic idle_check();
        @(posedge clk);
        @(negedge clk);
        check("idle_done",  bus.done, 0);
        check("idle_trunc", bus.trunc, 0);
        check("idle_gnt",   bus.gnt, 0);
        check("idle_busy",  bus.busy, 0);
        check("idle_vol",   bus.vol, mvol);
    endtask

    initial begin
        comps   = 0;
        fails   = 0;
        mvol    = 0;
        mlast   = NREQ - 1;
        rst_n   = 1'b0;
        bus.req = '0;
        bus.dir = '0;
        bus.len = '0;

        do_reset();
        set_req(0, 1'b1, 5);
        serve_one(1'b0);
        idle_check();

        // Two fillers re-raising after each done: alternation 0,1,0,1.
        do_reset();
        set_req(0, 1'b1, 2);
        set_req(1, 1'b1, 2);
        for (int t = 0; t < 4; t++) begin
            serve_one(1'b1);
            set_req(mlast, 1'b1, 2);
        end
        bus.req = '0;
        idle_check();

        do_reset();
        set_req(0, 1'b0, 3);
        serve_one(1'b0);
        set_req(0, 1'b1, 4);
        serve_one(1'b0);
        set_req(1, 1'b1, 15);
        serve_one(1'b0);
        set_req(0, 1'b1, 0);
        serve_one(1'b0);
        idle_check();

        do_reset();
        set_req(0, 1'b1, 4);
        serve_one(1'b0);
        set_req(1, 1'b1, 6);
        serve_one(1'b0);

        // Reset in the middle of a fill burst at vol 7.
        do_reset();
        set_req(0, 1'b1, 4);
        serve_one(1'b0);
        set_req(1, 1'b1, 10);
        @(posedge clk);
        @(negedge clk);
        check("mid_grant", bus.gnt, 2);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("mid_vol7", bus.vol, 7);
        rst_n   = 1'b0;
        bus.req = '0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_vol",  bus.vol, 0);
        check("mid_rst_gnt",  bus.gnt, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        mvol  = 0;
        mlast = NREQ - 1;
        set_req(0, 1'b1, 1);
        set_req(1, 1'b1, 1);
        serve_one(1'b0);
        check("rr_after_reset", mlast, 0);
        serve_one(1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i] && ($urandom_range(0, 3) != 0)) begin
                    set_req(i, 1'($urandom), int'($urandom_range(0, 12)));
                end
            end
            if (bus.req == '0) set_req(0, 1'($urandom), int'($urandom_range(0, 12)));
            serve_one(1'($urandom));
        end
        bus.req = '0;
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule
